spi_sram_responder: RTL

- Synthesizable responder for the serial SRAM command stream that our memory controller emits on PMOD1.
- Decodes the instruction byte, the 24-bit address and the 16-bit data field, and serves reads and writes from an internal word array.
- Used on-chip as an SRAM stand-in for bring-up and as the reference responder in controller benches.
- Runs in lockstep with the initiator: one bit per clk edge while sram_cs_n is low, with no separate serial clock.

---
 rtl/spi_sram_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_sram_responder.sv
// Serial SRAM responder: decodes READ (0x03) / WRITE (0x02) frames clocked one bit per clk
// edge while selected, and serves 16-bit words from an internal register array.
module spi_sram_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int ADDR_BITS  = 17,
  parameter int WORD_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  sram_cs_n,
  input  logic                  sram_si,
  output logic                  sram_so,
  input  logic [DEPTH_LOG2-1:0] peek_addr,
  output logic [WORD_BITS-1:0]  peek_data,
  output logic                  xfer_done,
  output logic                  xfer_write,
  output logic [ADDR_BITS-1:0]  xfer_addr,
  output logic [2:0]            dbg_state
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_RD   = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [5:0]            r_slot;
  logic [7:0]            r_cmd;
  logic                  r_is_write;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [WORD_BITS-1:0]  r_data;
  logic                  r_so;
  logic                  r_done;
  logic                  r_done_write;
  logic [ADDR_BITS-1:0]  r_done_addr;
  logic [WORD_BITS-1:0]  r_mem [DEPTH];

  logic                  w_active;
  logic [7:0]            w_cmd;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [WORD_BITS-1:0]  w_wdata;
  logic                  w_load_rd;
  logic                  w_rd_fin;
  logic                  w_commit;

  // The incoming bit completes each field on its final slot, so decode from the shifted-in value.
  assign w_active = ena & ~sram_cs_n;
  assign w_cmd    = {r_cmd[6:0], sram_si};
  assign w_addr   = {r_addr[ADDR_BITS-2:0], sram_si};
  assign w_rd_idx = w_addr[DEPTH_LOG2:1];
  assign w_wr_idx = r_addr[DEPTH_LOG2:1];
  assign w_wdata  = {sram_si, r_data[WORD_BITS-1:1]};

  always_comb begin
    w_next    = r_state;
    w_load_rd = 1'b0;
    w_rd_fin  = 1'b0;
    w_commit  = 1'b0;
    if (!w_active) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_CMD;
        S_CMD: begin
          if (r_slot == 6'd7) begin
            if (w_cmd == 8'h03 || w_cmd == 8'h02) w_next = S_ADDR;
            else                                  w_next = S_DONE;
          end
        end
        S_ADDR: begin
          if (r_slot == 6'd31) begin
            if (r_is_write) begin
              w_next = S_WR;
            end else begin
              w_next    = S_RD;
              w_load_rd = 1'b1;
            end
          end
        end
        S_RD: begin
          if (r_slot == 6'd46) begin
            w_next   = S_DONE;
            w_rd_fin = 1'b1;
          end
        end
        S_WR: begin
          if (r_slot == 6'd47) begin
            w_next   = S_DONE;
            w_commit = 1'b1;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_cmd        <= '0;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_so         <= 1'b0;
      r_done       <= 1'b0;
      r_done_write <= 1'b0;
      r_done_addr  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (!w_active) begin
        r_slot <= '0;
        r_so   <= 1'b0;
      end else begin
        if (r_state != S_DONE) r_slot <= r_slot + 6'd1;
        case (r_state)
          S_IDLE, S_CMD: r_cmd <= w_cmd;
          S_ADDR:        r_addr <= w_addr;
          S_RD: begin
            r_so   <= r_data[1];
            r_data <= r_data >> 1;
          end
          S_WR:          r_data <= w_wdata;
          default: ;
        endcase
        if (r_state == S_CMD && r_slot == 6'd7) r_is_write <= (w_cmd == 8'h02);
        if (w_load_rd) begin
          r_data <= r_mem[w_rd_idx];
          r_so   <= r_mem[w_rd_idx][0];
        end
        if (w_rd_fin || w_commit) begin
          r_done       <= 1'b1;
          r_done_write <= w_commit;
          r_done_addr  <= r_addr;
        end
      end
    end
  end

  // Array only changes on a completed write; aborted frames never reach slot 47.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[w_wr_idx] <= w_wdata;
    end
  end

  assign sram_so    = r_so;
  assign peek_data  = r_mem[peek_addr];
  assign xfer_done  = r_done;
  assign xfer_write = r_done_write;
  assign xfer_addr  = r_done_addr;
  assign dbg_state  = r_state;
endmodule
